// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide issue controller: handshakes with unsigned mul/div cores,
// applies signed operand/result fixup, owns HI/LO and stalls the pipeline while a core is busy.
module mdu_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               mul_start_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    output logic               mul_flush_o,
    input  logic               mul_ready_i,
    input  logic [2*WIDTH-1:0] mul_result_i,
    output logic               div_start_o,
    output logic [WIDTH-1:0]   div_a_o,
    output logic [WIDTH-1:0]   div_b_o,
    output logic               div_flush_o,
    input  logic               div_ready_i,
    input  logic [WIDTH-1:0]   div_quot_i,
    input  logic [WIDTH-1:0]   div_rem_i
);
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa, opb;
    logic             neg, negr;

    logic             a_neg, b_neg, is_signed, issue_mul, issue_div;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign a_neg     = a_i[WIDTH-1];
    assign b_neg     = b_i[WIDTH-1];
    assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
    // most-negative value stays itself under abs; the cores treat it as unsigned 2^(W-1)
    assign abs_a     = (is_signed && a_neg) ? -a_i : a_i;
    assign abs_b     = (is_signed && b_neg) ? -b_i : b_i;
    assign issue_mul = valid_i && ((op_i == OP_MULT) || (op_i == OP_MULTU));
    assign issue_div = valid_i && ((op_i == OP_DIV) || (op_i == OP_DIVU)) && (b_i != '0);

    assign prod_fix = neg  ? -mul_result_i : mul_result_i;
    assign quot_fix = neg  ? -div_quot_i   : div_quot_i;
    assign rem_fix  = negr ? -div_rem_i    : div_rem_i;

    // both cores see the same latched operand pair; only one is ever started at a time
    assign mul_a_o = opa;
    assign mul_b_o = opb;
    assign div_a_o = opa;
    assign div_b_o = opb;

    always_comb begin
        stall_o = 1'b0;
        if (!flush_i) begin
            case (state)
                IDLE:     stall_o = issue_mul || issue_div;
                MUL_WAIT: stall_o = 1'b1;
                DIV_WAIT: stall_o = 1'b1;
                DONE:     stall_o = 1'b0;
                default:  stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hi_o        <= HILO_RESET;
            lo_o        <= HILO_RESET;
            opa         <= '0;
            opb         <= '0;
            neg         <= 1'b0;
            negr        <= 1'b0;
            mul_start_o <= 1'b0;
            div_start_o <= 1'b0;
            mul_flush_o <= 1'b0;
            div_flush_o <= 1'b0;
        end else begin
            mul_start_o <= 1'b0;
            div_start_o <= 1'b0;
            mul_flush_o <= 1'b0;
            div_flush_o <= 1'b0;
            if (flush_i) begin
                // a ready arriving alongside the flush is dropped here
                state       <= IDLE;
                mul_flush_o <= (state == MUL_WAIT);
                div_flush_o <= (state == DIV_WAIT);
            end else begin
                case (state)
                    IDLE: begin
                        if (issue_mul || issue_div) begin
                            opa  <= abs_a;
                            opb  <= abs_b;
                            neg  <= is_signed && (a_neg ^ b_neg);
                            negr <= is_signed && a_neg;
                            if (issue_mul) begin
                                mul_start_o <= 1'b1;
                                state       <= MUL_WAIT;
                            end else begin
                                div_start_o <= 1'b1;
                                state       <= DIV_WAIT;
                            end
                        end else if (valid_i && op_i == OP_MTHI) begin
                            hi_o <= a_i;
                        end else if (valid_i && op_i == OP_MTLO) begin
                            lo_o <= a_i;
                        end
                    end
                    MUL_WAIT: begin
                        if (mul_ready_i) begin
                            {hi_o, lo_o} <= prod_fix;
                            state        <= DONE;
                        end
                    end
                    DIV_WAIT: begin
                        if (div_ready_i) begin
                            lo_o  <= quot_fix;
                            hi_o  <= rem_fix;
                            state <= DONE;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
